// File: rtl/bm_stmt_param_seq_pkg.sv
// Shared definitions for the bm_stmt_* statement-coverage benchmarks.
// The state codes are fixed so that every benchmark in the family reports
// IDLE=0, LOAD=1, RUN=2, DONE=3 on its out_state port.
package bm_stmt_param_seq_pkg;

  localparam int STATE_BITS = 2;

  typedef enum logic [STATE_BITS-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bm_stmt_prio_enc.sv
// bm_stmt_prio_enc: registered highest-set-bit priority encoder.
// Only built when BM_STMT_PRIO_EN is defined; the default build has no
// encoder logic at all, so this file is empty there.
`ifdef BM_STMT_PRIO_EN
module bm_stmt_prio_enc #(
  parameter int BITS = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [BITS-1:0] a_in,
  output logic [BITS-1:0] out_prio,
  output logic            out_prio_vld
);

  logic [BITS-1:0] prio_next;

  // Scan low to high so the highest set bit wins; unrolls to an if/else-if chain.
  always_comb begin
    prio_next = '0;
    for (int i = 0; i < BITS; i++) begin
      if (a_in[i]) begin
        prio_next = BITS'(i);
      end
    end
  end

  // Register the encoded index and the any-bit-set flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_prio     <= '0;
      out_prio_vld <= 1'b0;
    end else begin
      out_prio     <= prio_next;
      out_prio_vld <= |a_in;
    end
  end

endmodule
`endif

// File: rtl/bm_stmt_param_seq.sv
// bm_stmt_param_seq: parametrised statement-coverage micro benchmark.
// Registered inverter, b_in shift history, a 4-state start/count FSM with a
// bounded event counter, and an optional priority encoder enabled by
// defining BM_STMT_PRIO_EN (outputs tie to 0 otherwise).
module bm_stmt_param_seq
  import bm_stmt_param_seq_pkg::*;
#(
  parameter int BITS     = 4,
  parameter int CNT_BITS = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [BITS-1:0]       a_in,
  input  logic                  b_in,
  input  logic                  start,
  output logic [BITS-1:0]       out_inv,
  output logic [BITS-1:0]       out_hist,
  output logic [1:0]            out_state,
  output logic [CNT_BITS-1:0]   out_count,
  output logic                  out_done,
  output logic [BITS-1:0]       out_prio,
  output logic                  out_prio_vld
);

  state_t              state, state_next;
  logic [CNT_BITS-1:0] count, count_next;
  logic [CNT_BITS-1:0] limit, limit_next;
  logic [BITS-1:0]     inv_next;

  // Bitwise complement written as a per-bit case so each arm is a statement.
  always_comb begin
    inv_next = '0;
    for (int i = 0; i < BITS; i++) begin
      case (a_in[i])
        1'b1:    inv_next[i] = 1'b0;
        default: inv_next[i] = 1'b1;
      endcase
    end
  end

  // Datapath registers: inverted operand and b_in history (newest in bit 0).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_inv  <= '0;
      out_hist <= '0;
    end else begin
      out_inv  <= inv_next;
      out_hist <= {out_hist[BITS-2:0], b_in};
    end
  end

  // FSM state, event counter and captured limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      count <= '0;
      limit <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      limit <= limit_next;
    end
  end

  // Next-state logic; in RUN a restart beats both completion and counting,
  // and the count stops at limit so it can never wrap.
  always_comb begin
    state_next = state;
    count_next = count;
    limit_next = limit;
    case (state)
      ST_IDLE: begin
        if (start) begin
          limit_next = a_in[CNT_BITS-1:0];
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_next = '0;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (start) begin
          limit_next = a_in[CNT_BITS-1:0];
          state_next = ST_LOAD;
        end else if (count == limit) begin
          state_next = ST_DONE;
        end else if (b_in) begin
          count_next = count + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign out_state = state;
  assign out_count = count;
  assign out_done  = (state == ST_DONE);

`ifdef BM_STMT_PRIO_EN
  bm_stmt_prio_enc #(
    .BITS(BITS)
  ) u_prio (
    .clock       (clock),
    .reset_n     (reset_n),
    .a_in        (a_in),
    .out_prio    (out_prio),
    .out_prio_vld(out_prio_vld)
  );
`else
  assign out_prio     = '0;
  assign out_prio_vld = 1'b0;
`endif

endmodule

// File: tb/tb_bm_stmt_param_seq.sv
// tb_bm_stmt_param_seq: directed self-checking bench for bm_stmt_param_seq
// with BITS=4, CNT_BITS=3. Serves both builds of BM_STMT_PRIO_EN.
module tb_bm_stmt_param_seq;

  logic       clock;
  logic       reset_n;
  logic [3:0] a_in;
  logic       b_in;
  logic       start;
  logic [3:0] out_inv;
  logic [3:0] out_hist;
  logic [1:0] out_state;
  logic [2:0] out_count;
  logic       out_done;
  logic [3:0] out_prio;
  logic       out_prio_vld;

  int checks = 0;
  int errors = 0;

  bm_stmt_param_seq #(
    .BITS    (4),
    .CNT_BITS(3)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .a_in        (a_in),
    .b_in        (b_in),
    .start       (start),
    .out_inv     (out_inv),
    .out_hist    (out_hist),
    .out_state   (out_state),
    .out_count   (out_count),
    .out_done    (out_done),
    .out_prio    (out_prio),
    .out_prio_vld(out_prio_vld)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    a_in    = 4'b0000;
    b_in    = 1'b0;
    start   = 1'b0;
    reset_n = 1'b0;
    #12;
    checks++;
    if ({out_inv, out_hist, out_state, out_count, out_done} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got inv=%b hist=%b st=%0d cnt=%0d done=%b want all 0",
               out_inv, out_hist, out_state, out_count, out_done);
    end
    checks++;
    if ({out_prio, out_prio_vld} !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_prio got %0d/%b want 0/0", out_prio, out_prio_vld);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_inv_hist();
    logic [3:0] seq_b;
    a_in = 4'b0101;
    tick();
    checks++;
    if (out_inv !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL inv_0101 got %b want 1010", out_inv);
    end
    a_in = 4'b1111;
    tick();
    checks++;
    if (out_inv !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL inv_1111 got %b want 0000", out_inv);
    end
    seq_b = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      b_in = seq_b[i];
      tick();
    end
    b_in = 1'b0;
    checks++;
    if (out_hist !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL hist_1011 got %b want 1011", out_hist);
    end
    // FSM must not have moved without start.
    checks++;
    if (out_state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL idle_no_start got %0d want 0", out_state);
    end
  endtask

  task automatic test_normal();
    logic [1:0] exp_st  [7] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
    logic [2:0] exp_cnt [7] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
    a_in  = 4'b0011;
    start = 1'b1;
    b_in  = 1'b0;
    for (int e = 0; e < 7; e++) begin
      tick();
      start = 1'b0;
      b_in  = 1'b1;
      checks++;
      if (out_state !== exp_st[e] || out_count !== exp_cnt[e]) begin
        errors++;
        $display("[TB] FAIL normal_edge%0d got st=%0d cnt=%0d want st=%0d cnt=%0d",
                 e + 1, out_state, out_count, exp_st[e], exp_cnt[e]);
      end
      checks++;
      if (out_done !== (e == 5)) begin
        errors++;
        $display("[TB] FAIL normal_done_edge%0d got %b want %b", e + 1, out_done, (e == 5));
      end
    end
    b_in = 1'b0;
  endtask

  task automatic test_zero_limit();
    a_in  = 4'b1000;
    start = 1'b1;
    b_in  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (out_state !== 2'd3 || out_done !== 1'b1 || out_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL zero_limit got st=%0d done=%b cnt=%0d want st=3 done=1 cnt=0",
               out_state, out_done, out_count);
    end
    tick();
    b_in = 1'b0;
    checks++;
    if (out_state !== 2'd0 || out_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_limit_idle got st=%0d done=%b want st=0 done=0", out_state, out_done);
    end
  endtask

  task automatic test_held_count();
    a_in  = 4'b0010;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    b_in = 1'b1;
    tick();
    b_in = 1'b0;
    tick();
    checks++;
    if (out_state !== 2'd2 || out_count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL held_count got st=%0d cnt=%0d want st=2 cnt=1", out_state, out_count);
    end
    b_in = 1'b1;
    tick();
    b_in = 1'b0;
    checks++;
    if (out_count !== 3'd2 || out_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_second_event got cnt=%0d done=%b want cnt=2 done=0", out_count, out_done);
    end
    tick();
    checks++;
    if (out_done !== 1'b1 || out_count !== 3'd2) begin
      errors++;
      $display("[TB] FAIL held_done got done=%b cnt=%0d want done=1 cnt=2", out_done, out_count);
    end
    tick();
  endtask

  task automatic test_restart();
    a_in  = 4'b0011;
    start = 1'b1;
    tick();
    start = 1'b0;
    b_in  = 1'b1;
    tick();
    tick();
    // In RUN with count=1: restart together with b_in.
    a_in  = 4'b0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (out_state !== 2'd1 || out_count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL restart_load got st=%0d cnt=%0d want st=1 cnt=1", out_state, out_count);
    end
    tick();
    checks++;
    if (out_state !== 2'd2 || out_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL restart_cleared got st=%0d cnt=%0d want st=2 cnt=0", out_state, out_count);
    end
    tick();
    tick();
    checks++;
    if (out_done !== 1'b1 || out_count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL restart_done got done=%b cnt=%0d want done=1 cnt=1", out_done, out_count);
    end
    b_in = 1'b0;
    tick();
  endtask

  task automatic test_restart_beats_done();
    a_in  = 4'b0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    b_in  = 1'b1;
    tick();
    tick();
    b_in = 1'b0;
    // count == limit == 1 now; start must win over DONE.
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (out_state !== 2'd1 || out_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_vs_done got st=%0d done=%b want st=1 done=0", out_state, out_done);
    end
    tick();
    tick();
    b_in = 1'b1;
    tick();
    tick();
    b_in = 1'b0;
    checks++;
    if (out_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_vs_done_finish got done=%b want 1", out_done);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    a_in  = 4'b0001;
    start = 1'b1;
    tick();
    a_in = 4'b0111;
    tick();
    start = 1'b0;
    checks++;
    if (out_state !== 2'd2 || out_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL start_in_load got st=%0d cnt=%0d want st=2 cnt=0", out_state, out_count);
    end
    b_in = 1'b1;
    tick();
    tick();
    b_in = 1'b0;
    checks++;
    if (out_done !== 1'b1 || out_count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL load_limit_kept got done=%b cnt=%0d want done=1 cnt=1", out_done, out_count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (out_state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL start_in_done got st=%0d want 0", out_state);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int seen_done = 0;
    a_in  = 4'b0011;
    start = 1'b1;
    tick();
    start = 1'b0;
    b_in  = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (out_count !== 3'd2) begin
      errors++;
      $display("[TB] FAIL mid_run_setup got cnt=%0d want 2", out_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_state !== 2'd0 || out_count !== 3'd0 || out_inv !== 4'd0 || out_hist !== 4'd0 || out_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_run_reset got st=%0d cnt=%0d inv=%b hist=%b done=%b want all 0",
               out_state, out_count, out_inv, out_hist, out_done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_done === 1'b1 || out_state !== 2'd0) seen_done++;
    end
    b_in = 1'b0;
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("[TB] FAIL no_done_after_reset got %0d bad cycles want 0", seen_done);
    end
  endtask

  task automatic test_prio();
    logic [3:0] vec_a   [4] = '{4'b0110, 4'b0000, 4'b1000, 4'b0001};
    logic [3:0] exp_p   [4];
    logic       exp_v   [4];
`ifdef BM_STMT_PRIO_EN
    exp_p = '{4'd2, 4'd0, 4'd3, 4'd0};
    exp_v = '{1'b1, 1'b0, 1'b1, 1'b1};
`else
    exp_p = '{4'd0, 4'd0, 4'd0, 4'd0};
    exp_v = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      a_in = vec_a[i];
      tick();
      checks++;
      if (out_prio !== exp_p[i] || out_prio_vld !== exp_v[i]) begin
        errors++;
        $display("[TB] FAIL prio_%b got %0d/%b want %0d/%b",
                 vec_a[i], out_prio, out_prio_vld, exp_p[i], exp_v[i]);
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_inv_hist();
    test_normal();
    test_zero_limit();
    test_held_count();
    test_restart();
    test_restart_beats_done();
    test_ignored_start();
    test_reset_mid_run();
    test_prio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
